// File: rtl/cond_pipe_ctrl.sv
// Conditional-execution pipeline control: carries decode controls through E/M/W,
// evaluates the ARM condition field against the NZCV register and gates writes.
module cond_pipe_ctrl #(
   parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       FlushE,
   input  logic       PCSrcD,
   input  logic       BranchD,
   input  logic       RegWriteD,
   input  logic       MemWriteD,
   input  logic       MemtoRegD,
   input  logic       AluSrcD,
   input  logic [3:0] AluControlD,
   input  logic [1:0] FlagWriteD,
   input  logic [3:0] CondD,
   input  logic [3:0] ALUFlags,
   output logic [3:0] AluControlE,
   output logic       AluSrcE,
   output logic       CondExE,
   output logic       BranchTakenE,
   output logic [3:0] FlagsE,
   output logic       PCSrcM,
   output logic       RegWriteM,
   output logic       MemWriteM,
   output logic       MemtoRegM,
   output logic       PCSrcW,
   output logic       RegWriteW,
   output logic       MemtoRegW,
   output logic       PCWrPendingF
);

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   // E-stage registers
   logic       r_pcsrc_e;
   logic       r_branch_e;
   logic       r_regwrite_e;
   logic       r_memwrite_e;
   logic       r_memtoreg_e;
   logic       r_alusrc_e;
   logic [3:0] r_alucontrol_e;
   logic [1:0] r_flagwrite_e;
   logic [3:0] r_cond_e;

   logic [3:0] r_flags;

   // M- and W-stage registers
   logic       r_pcsrc_m;
   logic       r_regwrite_m;
   logic       r_memwrite_m;
   logic       r_memtoreg_m;
   logic       r_pcsrc_w;
   logic       r_regwrite_w;
   logic       r_memtoreg_w;

   logic       w_n;
   logic       w_z;
   logic       w_c;
   logic       w_v;
   logic       w_cond_ex;
   logic       w_bubble;

   assign {w_n, w_z, w_c, w_v} = r_flags;
   assign w_bubble = RESET | FlushE;

   // Evaluated on the flags before this instruction's own update lands.
   always_comb begin
      w_cond_ex = 1'b0;
      case (r_cond_e)
         COND_EQ: w_cond_ex = w_z;
         COND_NE: w_cond_ex = ~w_z;
         COND_CS: w_cond_ex = w_c;
         COND_CC: w_cond_ex = ~w_c;
         COND_MI: w_cond_ex = w_n;
         COND_PL: w_cond_ex = ~w_n;
         COND_VS: w_cond_ex = w_v;
         COND_VC: w_cond_ex = ~w_v;
         COND_HI: w_cond_ex = w_c & ~w_z;
         COND_LS: w_cond_ex = ~w_c | w_z;
         COND_GE: w_cond_ex = ~(w_n ^ w_v);
         COND_LT: w_cond_ex = w_n ^ w_v;
         COND_GT: w_cond_ex = ~w_z & ~(w_n ^ w_v);
         COND_LE: w_cond_ex = w_z | (w_n ^ w_v);
         COND_AL: w_cond_ex = 1'b1;
         default: w_cond_ex = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (w_bubble) begin
         r_pcsrc_e      <= 1'b0;
         r_branch_e     <= 1'b0;
         r_regwrite_e   <= 1'b0;
         r_memwrite_e   <= 1'b0;
         r_memtoreg_e   <= 1'b0;
         r_alusrc_e     <= 1'b0;
         r_alucontrol_e <= 4'b0000;
         r_flagwrite_e  <= 2'b00;
         r_cond_e       <= COND_AL;
      end else begin
         r_pcsrc_e      <= PCSrcD;
         r_branch_e     <= BranchD;
         r_regwrite_e   <= RegWriteD;
         r_memwrite_e   <= MemWriteD;
         r_memtoreg_e   <= MemtoRegD;
         r_alusrc_e     <= AluSrcD;
         r_alucontrol_e <= AluControlD;
         r_flagwrite_e  <= FlagWriteD;
         r_cond_e       <= CondD;
      end
   end

   // Flush only bubbles E; the instruction leaving E still commits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_flags <= FLAGS_INIT;
      end else begin
         if (r_flagwrite_e[1] & w_cond_ex) begin
            r_flags[3:2] <= ALUFlags[3:2];
         end
         if (r_flagwrite_e[0] & w_cond_ex) begin
            r_flags[1:0] <= ALUFlags[1:0];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pcsrc_m    <= 1'b0;
         r_regwrite_m <= 1'b0;
         r_memwrite_m <= 1'b0;
         r_memtoreg_m <= 1'b0;
         r_pcsrc_w    <= 1'b0;
         r_regwrite_w <= 1'b0;
         r_memtoreg_w <= 1'b0;
      end else begin
         r_pcsrc_m    <= r_pcsrc_e & w_cond_ex;
         r_regwrite_m <= r_regwrite_e & w_cond_ex;
         r_memwrite_m <= r_memwrite_e & w_cond_ex;
         r_memtoreg_m <= r_memtoreg_e;
         r_pcsrc_w    <= r_pcsrc_m;
         r_regwrite_w <= r_regwrite_m;
         r_memtoreg_w <= r_memtoreg_m;
      end
   end

   assign AluControlE  = r_alucontrol_e;
   assign AluSrcE      = r_alusrc_e;
   assign CondExE      = w_cond_ex;
   assign BranchTakenE = r_branch_e & w_cond_ex;
   assign FlagsE       = r_flags;
   assign PCSrcM       = r_pcsrc_m;
   assign RegWriteM    = r_regwrite_m;
   assign MemWriteM    = r_memwrite_m;
   assign MemtoRegM    = r_memtoreg_m;
   assign PCSrcW       = r_pcsrc_w;
   assign RegWriteW    = r_regwrite_w;
   assign MemtoRegW    = r_memtoreg_w;
   assign PCWrPendingF = PCSrcD | r_pcsrc_e | r_pcsrc_m;

endmodule
